systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 139 +++++++++++++
 tb/tb_systolic_feeder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Skewed A/B edge feeder for an N x N output-stationary systolic array.
// Optional pe_rst_n clear phase before each job is compiled in by SYSTOLIC_FEEDER_AUTO_CLEAR_EN.
module systolic_feeder #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic                      wr_sel,
  input  logic [$clog2(N*K)-1:0]    wr_addr,
  input  logic [7:0]                wr_data,
  input  logic                      start,
  output logic [N*8-1:0]            a_edge,
  output logic [N*8-1:0]            b_edge,
  output logic                      pe_rst_n,
  output logic                      busy,
  output logic                      done
);

  localparam int NK = N * K;
  localparam int AW = $clog2(NK);
  localparam int SL = K + N - 1;
  localparam int CW = $clog2(K + N);
  localparam logic [AW:0] NK_EXT = NK[AW:0];

  typedef enum logic [2:0] {
    IDLE,
`ifdef SYSTOLIC_FEEDER_AUTO_CLEAR_EN
    CLEAR,
`endif
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic [7:0]    a_buf [NK];
  logic [7:0]    b_buf [NK];
  logic [7:0]    a_eff [NK];
  logic [7:0]    b_eff [NK];
  logic [N*8-1:0] a_next, b_next;
  logic          wr_ok;

  assign wr_ok = wr_en && (state == IDLE) && ({1'b0, wr_addr} < NK_EXT);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NK; n++) begin
        a_buf[n] <= '0;
        b_buf[n] <= '0;
      end
    end else if (wr_ok) begin
      if (wr_sel) b_buf[wr_addr] <= wr_data;
      else        a_buf[wr_addr] <= wr_data;
    end
  end

  // A write landing in the same cycle as start must already be visible to step 0.
  always_comb begin
    a_eff = a_buf;
    b_eff = b_buf;
    if (wr_ok) begin
      if (wr_sel) b_eff[wr_addr] = wr_data;
      else        a_eff[wr_addr] = wr_data;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = '0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef SYSTOLIC_FEEDER_AUTO_CLEAR_EN
          next_state = CLEAR;
`else
          next_state = STREAM;
`endif
        end
      end
`ifdef SYSTOLIC_FEEDER_AUTO_CLEAR_EN
      CLEAR: next_state = STREAM;
`endif
      STREAM: begin
        if (cnt == CW'(SL - 1)) next_state = DRAIN;
        else                    next_cnt   = cnt + 1'b1;
      end
      DRAIN: begin
        if (cnt == CW'(N - 1)) next_state = DONE;
        else                   next_cnt   = cnt + 1'b1;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Row i lags by i steps and column j by j steps, producing the diagonal wavefront.
  always_comb begin
    a_next = '0;
    b_next = '0;
    if (next_state == STREAM) begin
      for (int i = 0; i < N; i++) begin
        if ((int'(next_cnt) >= i) && (int'(next_cnt) - i < K))
          a_next[8*i +: 8] = a_eff[AW'(i * K + int'(next_cnt) - i)];
      end
      for (int j = 0; j < N; j++) begin
        if ((int'(next_cnt) >= j) && (int'(next_cnt) - j < K))
          b_next[8*j +: 8] = b_eff[AW'((int'(next_cnt) - j) * N + j)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a_edge   <= '0;
      b_edge   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pe_rst_n <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      a_edge   <= a_next;
      b_edge   <= b_next;
      busy     <= (next_state != IDLE);
      done     <= (next_state == DONE);
`ifdef SYSTOLIC_FEEDER_AUTO_CLEAR_EN
      pe_rst_n <= (next_state != CLEAR);
`else
      pe_rst_n <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder at N=2, K=2; follows SYSTOLIC_FEEDER_AUTO_CLEAR_EN for the clear-cycle offset.
module tb_systolic_feeder;

`ifdef SYSTOLIC_FEEDER_AUTO_CLEAR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic        wr_sel;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        start;
  logic [15:0] a_edge;
  logic [15:0] b_edge;
  logic        pe_rst_n;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a_vals;
    logic [31:0] b_vals;
    logic [47:0] exp_a;
    logic [47:0] exp_b;
  } vec_t;

  vec_t vecs [3];

  systolic_feeder #(.N(2), .K(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .a_edge   (a_edge),
    .b_edge   (b_edge),
    .pe_rst_n (pe_rst_n),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic writeElem(input logic sel, input logic [1:0] addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic applyStimulus(input int idx);
    for (int k = 0; k < 4; k++) writeElem(1'b0, 2'(k), vecs[idx].a_vals[8*k +: 8]);
    for (int k = 0; k < 4; k++) writeElem(1'b1, 2'(k), vecs[idx].b_vals[8*k +: 8]);
  endtask

  // Pulses start (alongside any write the caller set up) and checks every cycle through return to IDLE.
  task automatic checkJob(input string name, input logic [47:0] exp_a, input logic [47:0] exp_b);
    int s;
    logic [15:0] ea, eb;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    for (int c = 1; c <= 7 + CLR; c++) begin
      s  = c - 1 - CLR;
      ea = (s >= 0 && s <= 2) ? exp_a[16*s +: 16] : 16'h0;
      eb = (s >= 0 && s <= 2) ? exp_b[16*s +: 16] : 16'h0;
      checkOutput($sformatf("%s c%0d a_edge", name, c), 32'(a_edge), 32'(ea));
      checkOutput($sformatf("%s c%0d b_edge", name, c), 32'(b_edge), 32'(eb));
      checkOutput($sformatf("%s c%0d done", name, c), 32'(done), 32'(c == 6 + CLR));
      checkOutput($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(c <= 6 + CLR));
      checkOutput($sformatf("%s c%0d pe_rst_n", name, c), 32'(pe_rst_n), 32'(!(CLR == 1 && c == 1)));
      tick();
    end
  endtask

  initial begin
    int done_cnt;
    int done_at;

    vecs[0] = '{32'h04030201, 32'h08070605, 48'h0400_0302_0001, 48'h0800_0607_0005};
    vecs[1] = '{32'h03020180, 32'hC310FF7F, 48'h0300_0201_0080, 48'hC300_FF10_007F};
    vecs[2] = '{32'h44332211, 32'hDDCCBBAA, 48'h4400_3322_0011, 48'hDD00_BBCC_00AA};

    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    tick();
    tick();
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst pe_rst_n", 32'(pe_rst_n), 32'd0);
    checkOutput("rst a_edge", 32'(a_edge), 32'd0);
    checkOutput("rst b_edge", 32'(b_edge), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("post-rst pe_rst_n", 32'(pe_rst_n), 32'd1);

    for (int v = 0; v < 3; v++) begin
      applyStimulus(v);
      checkJob($sformatf("vec%0d", v), vecs[v].exp_a, vecs[v].exp_b);
    end

    // Write to A[0][0] in the same cycle as start must reach the stream.
    applyStimulus(0);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 8'h55;
    checkJob("bypass", 48'h0400_0302_0055, vecs[0].exp_b);

    // Writes while busy are dropped, so the rerun sees the original A[0][0].
    applyStimulus(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 8'd9;
    for (int c = 0; c < 5; c++) tick();
    wr_en = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    checkJob("busy-write", vecs[0].exp_a, vecs[0].exp_b);

    // Second start while busy is ignored.
    done_cnt = 0;
    done_at  = -1;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 15; c++) begin
      if (done) begin
        done_cnt++;
        done_at = c;
      end
      start = (c == 3);
      tick();
    end
    start = 1'b0;
    checkOutput("restart done count", 32'(done_cnt), 32'd1);
    checkOutput("restart done cycle", 32'(done_at), 32'(6 + CLR));
    checkOutput("restart idle busy", 32'(busy), 32'd0);

    // Reset mid-job aborts immediately and clears the buffers.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort a_edge", 32'(a_edge), 32'd0);
    checkOutput("abort b_edge", 32'(b_edge), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort pe_rst_n", 32'(pe_rst_n), 32'd0);
    reset = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) done_cnt++;
      tick();
    end
    checkOutput("abort no done", 32'(done_cnt), 32'd0);
    checkOutput("abort pe_rst_n after", 32'(pe_rst_n), 32'd1);
    checkJob("cleared", 48'h0, 48'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
